// File: rtl/spi_master_pkg.sv
// Shared types and constants for the push/pull SPI initiator.
// Optional build macro: SPI_MASTER_VAR_PKT_EN (variable packet length).
package spi_master_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      XFER  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } spi_master_state_t;

   localparam logic SCLK_IDLE   = 1'b0;
   localparam logic CS_INACTIVE = 1'b1;

   // Chip-select index width; a single select still needs a 1-bit address.
   function automatic int csw_of(input int ncs);
      return (ncs > 1) ? $clog2(ncs) : 1;
   endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side val/rdy recv/send bus of the SPI initiator.
// Optional build macro: SPI_MASTER_VAR_PKT_EN adds packet_size.
interface spi_master_if #(
   parameter int NBITS = 8,
   parameter int NCS   = 1
) ();
   import spi_master_pkg::*;

   localparam int CSW = csw_of(NCS);

   logic [NBITS-1:0] recv_msg;
   logic             recv_val;
   logic             recv_rdy;
   logic [CSW-1:0]   cs_addr;
   logic [NBITS-1:0] send_msg;
   logic             send_val;
   logic             send_rdy;

`ifdef SPI_MASTER_VAR_PKT_EN
   localparam int PSW = $clog2(NBITS + 1);
   logic [PSW-1:0]   packet_size;

   modport master (
      output recv_msg, recv_val, cs_addr, send_rdy, packet_size,
      input  recv_rdy, send_msg, send_val
   );
   modport slave (
      input  recv_msg, recv_val, cs_addr, send_rdy, packet_size,
      output recv_rdy, send_msg, send_val
   );
`else
   modport master (
      output recv_msg, recv_val, cs_addr, send_rdy,
      input  recv_rdy, send_msg, send_val
   );
   modport slave (
      input  recv_msg, recv_val, cs_addr, send_rdy,
      output recv_rdy, send_msg, send_val
   );
`endif

endinterface

// File: rtl/spi_master_push_pull_sclk_gen.sv
// SCLK divider: toggles every CLK_DIV cycles while enabled, starting low;
// rise/fall pulses flag the cycle in which the toggle is registered.
module spi_sclk_gen
   import spi_master_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic sclk,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int CW = $clog2(CLK_DIV + 1);

   logic [CW-1:0] cnt;
   logic          tick;

   assign tick       = en && (cnt == CW'(CLK_DIV - 1));
   assign rise_pulse = tick && !sclk;
   assign fall_pulse = tick && sclk;

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         cnt  <= '0;
         sclk <= SCLK_IDLE;
      end else if (tick) begin
         cnt  <= '0;
         sclk <= ~sclk;
      end else begin
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_master_push_pull.sv
// Mode-0 SPI initiator: one val/rdy message in, shifted MSB-first on MOSI, MISO word out.
// Optional build macro: SPI_MASTER_VAR_PKT_EN (per-transfer packet_size).
module spi_master_push_pull
   import spi_master_pkg::*;
#(
   parameter int NBITS   = 8,
   parameter int NCS     = 1,
   parameter int CLK_DIV = 2
) (
   input  logic              clk,
   input  logic              reset,
   spi_master_if.slave       bus,
   output logic              spi_sclk,
   output logic [NCS-1:0]    spi_cs_n,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int CSW = csw_of(NCS);
   localparam int BW  = $clog2(NBITS + 1);
   localparam int CW  = $clog2(CLK_DIV + 1);

   localparam logic [2:0] S_IDLE  = IDLE;
   localparam logic [2:0] S_START = START;
   localparam logic [2:0] S_XFER  = XFER;
   localparam logic [2:0] S_STOP  = STOP;
   localparam logic [2:0] S_DONE  = DONE;

   logic [2:0]       state;
   logic [NBITS-1:0] shreg;
   logic [CSW-1:0]   cs_q;
   logic [BW-1:0]    bit_cnt;
   logic [CW-1:0]    phase;
   logic             miso_q;
   logic             sclk_en, rise, fall, phase_end;
   logic             recv_xfer, send_xfer, cs_active;
   logic [BW-1:0]    load_len;
   logic [NBITS-1:0] load_word;

`ifdef SPI_MASTER_VAR_PKT_EN
   // Short packets are left-aligned so the shift path is length-agnostic; after L
   // shifts the captured bits land right-aligned with zeros above them.
   always_comb begin
      load_len = bus.packet_size;
      if (bus.packet_size == '0 || bus.packet_size > BW'(NBITS))
         load_len = BW'(NBITS);
      load_word = bus.recv_msg << (BW'(NBITS) - load_len);
   end
`else
   assign load_len  = BW'(NBITS);
   assign load_word = bus.recv_msg;
`endif

   assign recv_xfer = bus.recv_val && bus.recv_rdy;
   assign send_xfer = bus.send_val && bus.send_rdy;
   assign phase_end = (phase == CW'(CLK_DIV - 1));
   assign sclk_en   = (state == S_XFER);
   assign cs_active = (state == S_START) || (state == S_XFER);

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk        (clk),
      .reset      (reset),
      .en         (sclk_en),
      .sclk       (spi_sclk),
      .rise_pulse (rise),
      .fall_pulse (fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         shreg   <= '0;
         cs_q    <= '0;
         bit_cnt <= '0;
         phase   <= '0;
         miso_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (recv_xfer) begin
                  shreg   <= load_word;
                  cs_q    <= bus.cs_addr;
                  bit_cnt <= load_len;
                  phase   <= '0;
                  state   <= S_START;
               end
            end
            S_START: begin
               if (phase_end) begin
                  phase <= '0;
                  state <= S_XFER;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            S_XFER: begin
               if (rise) begin
                  miso_q  <= spi_miso;
                  bit_cnt <= bit_cnt - 1'b1;
               end
               if (fall) begin
                  shreg <= {shreg[NBITS-2:0], miso_q};
                  if (bit_cnt == '0)
                     state <= S_STOP;
               end
            end
            S_STOP: begin
               if (phase_end) begin
                  phase <= '0;
                  state <= S_DONE;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            S_DONE: begin
               if (send_xfer)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.recv_rdy = (state == S_IDLE);
   assign bus.send_val = (state == S_DONE);
   assign bus.send_msg = shreg;
   assign spi_mosi     = cs_active ? shreg[NBITS-1] : 1'b0;

   // Out-of-range cs_q matches no index, so the transfer runs with no select asserted.
   always_comb begin
      spi_cs_n = {NCS{CS_INACTIVE}};
      if (cs_active) begin
         for (int unsigned i = 0; i < NCS; i++)
            if (32'(cs_q) == i)
               spi_cs_n[i] = ~CS_INACTIVE;
      end
   end

endmodule

// File: tb/tb_spi_master_push_pull.sv
// Directed bench for spi_master_push_pull (NBITS=8, NCS=4, CLK_DIV=2) with a mode-0 slave model.
// Build with SPI_MASTER_VAR_PKT_EN to also exercise variable packet lengths.
module tb_spi_master_push_pull;

   localparam int NBITS   = 8;
   localparam int NCS     = 4;
   localparam int CLK_DIV = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           spi_sclk, spi_mosi;
   logic           spi_miso = 1'b0;
   logic [NCS-1:0] spi_cs_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_master_if #(.NBITS(NBITS), .NCS(NCS)) bus ();

   spi_master_push_pull #(.NBITS(NBITS), .NCS(NCS), .CLK_DIV(CLK_DIV)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .spi_sclk (spi_sclk),
      .spi_cs_n (spi_cs_n),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso)
   );

   typedef struct {
      logic [7:0] msg, sw;
      logic [1:0] cs;
      logic [7:0] exp_send, exp_mosi;
      int         exp_lat;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one request, plays the slave (MISO changes after each SCLK fall), and
   // returns at the first negedge with send_val high, or lat=-1 on timeout.
   task automatic run_xfer(input logic [7:0] msg, input logic [7:0] sw, input logic [1:0] cs,
                           input int ps, output logic [7:0] mosi_bits, output int rises,
                           output int lat, output logic other_low, output logic sel_low);
      int   len, falls;
      logic prev_sclk;
      len = (ps == 0 || ps > NBITS) ? NBITS : ps;
      mosi_bits = '0; rises = 0; lat = -1; other_low = 1'b0; sel_low = 1'b0;
      falls = 0; prev_sclk = 1'b0;
      @(negedge clk);
      bus.recv_msg = msg;
      bus.cs_addr  = cs;
      bus.recv_val = 1'b1;
`ifdef SPI_MASTER_VAR_PKT_EN
      bus.packet_size = 4'(ps);
`endif
      spi_miso = sw[len-1];
      @(posedge clk);
      #1 bus.recv_val = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (spi_sclk && !prev_sclk && !spi_cs_n[cs]) begin
            rises++;
            mosi_bits = {mosi_bits[6:0], spi_mosi};
         end
         if (!spi_sclk && prev_sclk) begin
            falls++;
            spi_miso = (falls < len) ? sw[len-1-falls] : 1'b0;
         end
         if (!spi_cs_n[cs]) sel_low = 1'b1;
         for (int j = 0; j < NCS; j++)
            if (j != int'(cs) && !spi_cs_n[j]) other_low = 1'b1;
         prev_sclk = spi_sclk;
         if (bus.send_val) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic release_send();
      bus.send_rdy = 1'b1;
      @(negedge clk);
      bus.send_rdy = 1'b0;
      check("release_recv_rdy", bus.recv_rdy, 1);
      check("release_send_val", bus.send_val, 0);
   endtask

   initial begin
      logic [7:0] mosi_bits, held;
      int         rises, lat, bad, n;
      logic       other_low, sel_low, prev, seen;

      bus.recv_msg = '0; bus.recv_val = 1'b0; bus.cs_addr = '0; bus.send_rdy = 1'b0;
`ifdef SPI_MASTER_VAR_PKT_EN
      bus.packet_size = '0;
`endif
      vecs[0] = '{8'hA5, 8'h3C, 2'd0, 8'h3C, 8'hA5, 37};
      vecs[1] = '{8'hFF, 8'h00, 2'd2, 8'h00, 8'hFF, 37};
      vecs[2] = '{8'h00, 8'hFF, 2'd1, 8'hFF, 8'h00, 37};
      vecs[3] = '{8'h81, 8'h5A, 2'd3, 8'h5A, 8'h81, 37};
      vecs[4] = '{8'h6E, 8'hC1, 2'd0, 8'hC1, 8'h6E, 37};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_recv_rdy", bus.recv_rdy, 1);
      check("reset_send_val", bus.send_val, 0);
      check("reset_send_msg", bus.send_msg, 0);
      check("reset_sclk", spi_sclk, 0);
      check("reset_cs_n", spi_cs_n, 4'hF);
      check("reset_mosi", spi_mosi, 0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         run_xfer(vecs[i].msg, vecs[i].sw, vecs[i].cs, 0, mosi_bits, rises, lat, other_low, sel_low);
         check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         check($sformatf("v%0d_mosi", i), mosi_bits, vecs[i].exp_mosi);
         check($sformatf("v%0d_rises", i), rises, 8);
         check($sformatf("v%0d_send_msg", i), bus.send_msg, vecs[i].exp_send);
         check($sformatf("v%0d_sel_low", i), sel_low, 1);
         check($sformatf("v%0d_other_cs", i), other_low, 0);
         check($sformatf("v%0d_done_recv_rdy", i), bus.recv_rdy, 0);
         if (i == 0) begin
            bad = 0;
            held = bus.send_msg;
            repeat (20) begin
               @(negedge clk);
               if (!bus.send_val || bus.send_msg !== held || bus.recv_rdy ||
                   spi_sclk || spi_cs_n !== 4'hF || spi_mosi) bad++;
            end
            check("bp_hold", bad, 0);
         end
         release_send();
      end

      // Reset during XFER after three bits have been clocked.
      @(negedge clk);
      bus.recv_msg = 8'hC3; bus.cs_addr = 2'd1; bus.recv_val = 1'b1;
      @(posedge clk);
      #1 bus.recv_val = 1'b0;
      n = 0; prev = 1'b0;
      for (int k = 0; k < 100 && n < 3; k++) begin
         @(negedge clk);
         if (spi_sclk && !prev) n++;
         prev = spi_sclk;
      end
      check("mid_rises", n, 3);
      reset = 1'b1;
      @(negedge clk);
      check("mid_cs_n", spi_cs_n, 4'hF);
      check("mid_sclk", spi_sclk, 0);
      check("mid_mosi", spi_mosi, 0);
      check("mid_send_val", bus.send_val, 0);
      check("mid_recv_rdy", bus.recv_rdy, 1);
      reset = 1'b0;
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (bus.send_val || spi_sclk) seen = 1'b1;
      end
      check("mid_no_send", seen, 0);

`ifdef SPI_MASTER_VAR_PKT_EN
      run_xfer(8'h0B, 8'h0D, 2'd0, 4, mosi_bits, rises, lat, other_low, sel_low);
      check("pkt4_latency", lat, 21);
      check("pkt4_mosi", mosi_bits, 8'h0B);
      check("pkt4_rises", rises, 4);
      check("pkt4_send_msg", bus.send_msg, 8'h0D);
      release_send();
      run_xfer(8'h96, 8'h5A, 2'd2, 12, mosi_bits, rises, lat, other_low, sel_low);
      check("pkt12_latency", lat, 37);
      check("pkt12_mosi", mosi_bits, 8'h96);
      check("pkt12_rises", rises, 8);
      check("pkt12_send_msg", bus.send_msg, 8'h5A);
      release_send();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
